// File: rtl/mult_pkg.sv
// mult_pkg: shared op encoding, state enum and width default for the HI/LO multiply sequencer.
// MULT_HILO_MADD_EN widens the op code to add MADD/MADDU.
package mult_pkg;
    localparam int WIDTH_DEF = 32;
`ifdef MULT_HILO_MADD_EN
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU} mult_op_t;
`else
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO} mult_op_t;
`endif
    typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// mult_hilo_ctrl_if: execute-stage request, HI/LO results and multiplier operand/product bus.
interface mult_hilo_ctrl_if import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic               start;
    logic [OP_W-1:0]    op;
    logic [WIDTH-1:0]   rs;
    logic [WIDTH-1:0]   rt;
    logic               busy;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [2*WIDTH-1:0] mul_r;
    modport slave (input start, op, rs, rt, mul_r, output busy, hi, lo, mul_a, mul_b);
    modport master (output start, op, rs, rt, mul_r, input busy, hi, lo, mul_a, mul_b);
endinterface

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: operand magnitudes/sign on the way in, conditional negate of the product on the way out.
// MULT_HILO_MADD_EN adds accumulation onto the current {hi,lo}.
module mult_sign_fix import mult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic               sgn,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg,
    input  logic               neg_q,
    input  logic [2*WIDTH-1:0] mul_r,
`ifdef MULT_HILO_MADD_EN
    input  logic               acc,
    input  logic [2*WIDTH-1:0] hilo,
`endif
    output logic [2*WIDTH-1:0] res
);
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        // the most negative value maps onto itself, which is its correct unsigned magnitude
        mag_a = (sgn && rs[WIDTH-1]) ? -rs : rs;
        mag_b = (sgn && rt[WIDTH-1]) ? -rt : rt;
        neg   = sgn && (rs[WIDTH-1] ^ rt[WIDTH-1]);
        prod  = neg_q ? ~mul_r + 1'b1 : mul_r;
`ifdef MULT_HILO_MADD_EN
        res   = acc ? hilo + prod : prod;
`else
        res   = prod;
`endif
    end
endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequences MULT/MULTU/MTHI/MTLO through a fixed-latency multiplier into HI/LO.
// MULT_HILO_MADD_EN enables MADD/MADDU accumulate.
module mult_hilo_ctrl import mult_pkg::*; #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = WIDTH_DEF
) (
    input logic              clk,
    input logic              reset,
    mult_hilo_ctrl_if.slave  bus
);
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] res;
    logic               neg_in, is_mul, is_sgn;
`ifdef MULT_HILO_MADD_EN
    logic               acc_q, acc_d;
    assign is_mul = bus.op == OP_MULT || bus.op == OP_MULTU || bus.op == OP_MADD || bus.op == OP_MADDU;
    assign is_sgn = bus.op == OP_MULT || bus.op == OP_MADD;
`else
    assign is_mul = bus.op == OP_MULT || bus.op == OP_MULTU;
    assign is_sgn = bus.op == OP_MULT;
`endif
    mult_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .sgn(is_sgn), .rs(bus.rs), .rt(bus.rt), .mag_a(mag_a), .mag_b(mag_b), .neg(neg_in),
        .neg_q(neg_q), .mul_r(bus.mul_r),
`ifdef MULT_HILO_MADD_EN
        .acc(acc_q), .hilo({hi_q, lo_q}),
`endif
        .res(res)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MULT_HILO_MADD_EN
        acc_d   = acc_q;
`endif
        if (state_q == IDLE && bus.start) begin
            if (is_mul) begin
                a_d     = mag_a;
                b_d     = mag_b;
                neg_d   = neg_in;
                cnt_d   = 4'(LATENCY);
                state_d = WAIT;
`ifdef MULT_HILO_MADD_EN
                acc_d   = bus.op == OP_MADD || bus.op == OP_MADDU;
`endif
            end
            hi_d = bus.op == OP_MTHI ? bus.rs : hi_d;
            lo_d = bus.op == OP_MTLO ? bus.rs : lo_d;
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
            state_d = cnt_q != 4'd0 ? WAIT : IDLE;
            {hi_d, lo_d} = cnt_q != 4'd0 ? {hi_q, lo_q} : res;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef MULT_HILO_MADD_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef MULT_HILO_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end
    assign bus.busy  = state_q == WAIT;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.mul_a = a_q;
    assign bus.mul_b = b_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: directed checks of mult_hilo_ctrl beside a one-cycle registered multiplier model.
module tb_mult_hilo_ctrl;
    import mult_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    mult_hilo_ctrl_if #(.WIDTH(32)) bus ();
    mult_hilo_ctrl #(.LATENCY(1), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always_ff @(posedge clk) bus.mul_r <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start = 1'b1;
        bus.op = op;
        bus.rs = rs;
        bus.rt = rt;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op = '0;
        bus.rs = '0;
        bus.rt = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 64'd0);
        @(negedge clk) reset = 1'b0;
        // MULTU 5*7 aborted by reset mid-WAIT
        issue(OP_MULTU, 32'd5, 32'd7);
        chk("abort_busy_on", 64'(bus.busy), 64'd1);
        chk("abort_ab", {bus.mul_a, bus.mul_b}, {32'd5, 32'd7});
        reset = 1'b1;
        #1;
        chk("abort_busy_off", 64'(bus.busy), 64'd0);
        chk("abort_hilo_now", {bus.hi, bus.lo}, 64'd0);
        #1 reset = 1'b0;
        tick(); tick(); tick();
        chk("abort_hilo_later", {bus.hi, bus.lo}, 64'd0);
        chk("abort_busy_later", 64'(bus.busy), 64'd0);
        // MULTU max*max, busy for exactly two cycles
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mulu_busy_e0", 64'(bus.busy), 64'd1);
        chk("mulu_hilo_e0", {bus.hi, bus.lo}, 64'd0);
        tick();
        chk("mulu_busy_e1", 64'(bus.busy), 64'd1);
        tick();
        chk("mulu_busy_e2", 64'(bus.busy), 64'd0);
        chk("mulu_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        // MULT corner: most negative squared and times one
        issue(OP_MULT, 32'h80000000, 32'h80000000);
        chk("mult_min_ab", {bus.mul_a, bus.mul_b}, {32'h80000000, 32'h80000000});
        tick(); tick();
        chk("mult_minmin", {bus.hi, bus.lo}, 64'h40000000_00000000);
        issue(OP_MULT, 32'h80000000, 32'd1);
        tick(); tick();
        chk("mult_min_one", {bus.hi, bus.lo}, 64'hFFFFFFFF_80000000);
        // MULT -3*7 with an MTHI pulsed while busy
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        chk("mult_neg_ab", {bus.mul_a, bus.mul_b}, {32'd3, 32'd7});
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.rs = 32'h1234;
        tick(); tick();
        bus.start = 1'b0;
        chk("mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mult_neg_ab_hold", {bus.mul_a, bus.mul_b}, {32'd3, 32'd7});
        tick();
        chk("ignored_mthi", 64'(bus.hi), 64'hFFFFFFFF);
        // moves never raise busy
        issue(OP_MTLO, 32'hDEADBEEF, 32'd0);
        chk("mtlo_lo", 64'(bus.lo), 64'hDEADBEEF);
        chk("mtlo_hi", 64'(bus.hi), 64'hFFFFFFFF);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);
        issue(OP_MTHI, 32'hCAFEF00D, 32'd0);
        chk("mthi", {bus.hi, bus.lo}, 64'hCAFEF00D_DEADBEEF);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
`ifdef MULT_HILO_MADD_EN
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
        tick(); tick();
        chk("maddu", {bus.hi, bus.lo}, 64'h00000001_00000000);
        issue(OP_MADD, 32'hFFFFFFFF, 32'd1);
        tick(); tick();
        chk("madd", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
        issue(3'd6, 32'd9, 32'd9);
        chk("op6_busy", 64'(bus.busy), 64'd0);
        chk("op6_hilo", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequencer between the CPU execute stage and the 32x32->64 unsigned parallel multiplier.
- Accepts MULT/MULTU/MTHI/MTLO requests and sign-conditions operands into the multiplier.
- Waits the multiplier's fixed latency, sign-corrects the 64-bit product, and commits it to HI/LO.
- Drives busy so the pipeline stalls MFHI/MFLO and new multiplies until commit.

Parameters:
- LATENCY, 1, clock edges from mul_a/mul_b stable to mul_r valid; legal range 0..15.
- WIDTH, 32, operand width; product and {HI,LO} are 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request valid; sampled only when busy=0.
- op  input  2  0=MULT (signed), 1=MULTU, 2=MTHI, 3=MTLO.
- rs  input  WIDTH  operand A / move source.
- rt  input  WIDTH  operand B.
- busy  output  1  multiply in flight; high from the cycle after accept through the commit edge.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- mul_a  output  WIDTH  registered unsigned operand to the multiplier.
- mul_b  output  WIDTH  registered unsigned operand to the multiplier.
- mul_r  input  2*WIDTH  unsigned product from the multiplier.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, hi=0, lo=0, mul_a=0, mul_b=0, counter=0, neg flag=0.
- States: IDLE, WAIT.
- Reset during WAIT aborts the operation and leaves no partial HI/LO write.
- IDLE, start=1, op=MULTU:
  - mul_a<=rs, mul_b<=rt, neg<=0, counter<=LATENCY.
  - Go to WAIT.
- IDLE, start=1, op=MULT:
  - mul_a<=|rs|, mul_b<=|rt| (two's-complement magnitude), neg<=rs[msb]^rt[msb].
  - counter<=LATENCY; go to WAIT.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- IDLE, start=1, op=MTHI / MTLO:
  - hi<=rs (or lo<=rs) on the same edge.
  - Stay IDLE; busy stays 0.
- WAIT:
  - busy=1.
  - If counter!=0, decrement.
  - If counter==0, sample mul_r: {hi,lo}<= neg ? (~mul_r+1) : mul_r, truncated to 2*WIDTH.
  - On that commit edge return to IDLE; busy drops in the cycle after the commit edge.
- Timing, with the accept edge as edge 0:
  - mul_a/mul_b are valid after edge 0.
  - Commit occurs at edge LATENCY+1.
  - New hi/lo are visible after that edge.
  - busy is high for LATENCY+1 cycles.
- start while busy=1 is ignored entirely and not queued; the upstream holds start until busy=0.
- mul_a/mul_b hold their values after commit until the next accepted multiply.
- hi/lo are unchanged during WAIT; old values remain readable but consumers stall on busy.

Optional Feature:
- Macro: MULT_HILO_MADD_EN.
- Defined:
  - op widens to 3 bits; 4=MADD (signed), 5=MADDU.
  - Product formation is identical to MULT/MULTU.
  - Commit performs {hi,lo}<={hi,lo}+signed_product mod 2^(2*WIDTH).
  - Codes 6 and 7 are ignored.
- Undefined:
  - op is 2 bits; no accumulate path is synthesised.

Decomposition:
- Shared package mult_pkg holds:
  - op encoding enum mult_op_t (MULT, MULTU, MTHI, MTLO, plus MADD/MADDU under the macro);
  - state enum;
  - WIDTH default constant.
- One sub-module: mult_sign_fix, combinational.
  - Computes magnitude and neg flag on the input side.
  - Performs conditional 2*WIDTH negate (and accumulate under the macro) on the output side.
- Bench and top-level instantiate mult_hilo_ctrl beside the existing parallel multiplier, connecting mul_a/mul_b/mul_r.

Test Plan:
- Reset mid-WAIT after MULTU 5*7: assert reset -> busy=0, hi=lo=0 immediately; no later commit.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, LATENCY=1 -> busy high 2 cycles; hi=0xFFFFFFFE, lo=0x00000001 after edge 2.
- MULT rs=0x80000000, rt=0x80000000 -> hi=0x40000000, lo=0x00000000; MULT rs=0x80000000, rt=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> {hi,lo}=0xFFFFFFFF_FFFFFFEB; start pulsed during busy with MTHI 0x1234 -> ignored, hi still 0xFFFFFFFF.
- MTLO rs=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next edge, busy never asserts; then MTHI 0xCAFEF00D -> hi updated, lo unchanged.
- MULT_HILO_MADD_EN: {hi,lo}=0x0_FFFFFFFF, MADDU 1*1 -> hi=1, lo=0; then MADD -1*1 -> hi=0, lo=0xFFFFFFFF.
